// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter sequencer for the instruction-fetch stage.
// Owns the PC, turns decoded call/ret/jump requests into single-cycle pushes and
// pops on the return-address stack, waits out the stack's registered pop latency,
// and redirects fetch to a trap vector on a rising stack-fault flag.
//
// Ports:
//   clk           in   system clock, rising edge
//   reset         in   asynchronous active-high reset
//   stall         in   hold PC and drop requests (RUN only)
//   call          in   call request, target on callAddr
//   callAddr      in   call target
//   ret           in   return request
//   jump          in   unconditional jump request
//   jumpAddr      in   jump target
//   stackOut      in   popped address from the stack (registered in the stack)
//   stackOverflow in   sticky stack fault flag
//   pc            out  current fetch address
//   fetchValid    out  pc is valid for fetch (RUN only)
//   writeStack    out  push pulse
//   readStack     out  pop pulse
//   stackIn       out  push data (return address)
//   trap          out  sticky fault status, cleared only by reset
module pc_sequencer #(
    parameter int unsigned           PC_WIDTH     = 13,
    parameter logic [PC_WIDTH-1:0]   RESET_VECTOR = 13'h0000,
    parameter logic [PC_WIDTH-1:0]   TRAP_VECTOR  = 13'h0010
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                stall,
    input  logic                call,
    input  logic [PC_WIDTH-1:0] callAddr,
    input  logic                ret,
    input  logic                jump,
    input  logic [PC_WIDTH-1:0] jumpAddr,
    input  logic [PC_WIDTH-1:0] stackOut,
    input  logic                stackOverflow,
    output logic [PC_WIDTH-1:0] pc,
    output logic                fetchValid,
    output logic                writeStack,
    output logic                readStack,
    output logic [PC_WIDTH-1:0] stackIn,
    output logic                trap
);

    typedef enum logic [1:0] {
        StRun     = 2'd0,
        StRetReq  = 2'd1,
        StRetWait = 2'd2,
        StTrap    = 2'd3
    } state_e;

    state_e                state_q, state_d;
    logic [PC_WIDTH-1:0]   pc_q, pc_d;
    logic [PC_WIDTH-1:0]   stack_in_q, stack_in_d;
    logic                  write_q, write_d;
    logic                  read_q, read_d;
    logic                  trap_q, trap_d;
    logic                  ovf_prev_q;
    logic                  fault;
    logic [PC_WIDTH-1:0]   pc_inc;

    // The stack's fault flag is sticky, so only its rising edge is an event.
    assign fault  = stackOverflow & ~ovf_prev_q;
    assign pc_inc = pc_q + PC_WIDTH'(1);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        stack_in_d = stack_in_q;
        write_d    = 1'b0;
        read_d     = 1'b0;
        trap_d     = trap_q;

        if (fault) begin
            // Overrides any request in any state, including a pending pop load.
            state_d = StTrap;
        end else begin
            unique case (state_q)
                StRun: begin
                    if (!stall) begin
                        if (ret) begin
                            read_d  = 1'b1;
                            state_d = StRetReq;
                        end else if (call) begin
                            stack_in_d = pc_inc;
                            write_d    = 1'b1;
                            pc_d       = callAddr;
                        end else if (jump) begin
                            pc_d = jumpAddr;
                        end else begin
                            pc_d = pc_inc;
                        end
                    end
                end
                StRetReq: begin
                    state_d = StRetWait;
                end
                StRetWait: begin
                    pc_d    = stackOut;
                    state_d = StRun;
                end
                StTrap: begin
                    pc_d    = TRAP_VECTOR;
                    trap_d  = 1'b1;
                    state_d = StRun;
                end
                default: begin
                    state_d = StRun;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StRun;
            pc_q       <= RESET_VECTOR;
            stack_in_q <= '0;
            write_q    <= 1'b0;
            read_q     <= 1'b0;
            trap_q     <= 1'b0;
            ovf_prev_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            stack_in_q <= stack_in_d;
            write_q    <= write_d;
            read_q     <= read_d;
            trap_q     <= trap_d;
            ovf_prev_q <= stackOverflow;
        end
    end

    assign pc         = pc_q;
    assign fetchValid = (state_q == StRun);
    assign writeStack = write_q;
    assign readStack  = read_q;
    assign stackIn    = stack_in_q;
    assign trap       = trap_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with a small behavioural return-address stack.
module tb_pc_sequencer;

    localparam int unsigned W     = 13;
    localparam int unsigned DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          stall, call, ret, jump;
    logic [W-1:0]  callAddr, jumpAddr;
    logic [W-1:0]  stackOut;
    logic          stackOverflow;
    logic [W-1:0]  pc, stackIn;
    logic          fetchValid, writeStack, readStack, trap;

    int n_checks = 0;
    int n_errors = 0;

    pc_sequencer #(
        .PC_WIDTH     (W),
        .RESET_VECTOR (13'h0000),
        .TRAP_VECTOR  (13'h0010)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .call          (call),
        .callAddr      (callAddr),
        .ret           (ret),
        .jump          (jump),
        .jumpAddr      (jumpAddr),
        .stackOut      (stackOut),
        .stackOverflow (stackOverflow),
        .pc            (pc),
        .fetchValid    (fetchValid),
        .writeStack    (writeStack),
        .readStack     (readStack),
        .stackIn       (stackIn),
        .trap          (trap)
    );

    always #5 clk = ~clk;

    // Return-address stack: registered pop data, sticky fault on full push / empty pop.
    logic [W-1:0] mem [DEPTH];
    int           sp;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            sp            <= 0;
            stackOut      <= '0;
            stackOverflow <= 1'b0;
        end else if (writeStack) begin
            if (sp == DEPTH) stackOverflow <= 1'b1;
            else begin
                mem[sp] <= stackIn;
                sp      <= sp + 1;
            end
        end else if (readStack) begin
            if (sp == 0) stackOverflow <= 1'b1;
            else begin
                stackOut <= mem[sp-1];
                sp       <= sp - 1;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs change just after the falling edge; outputs are sampled there too.
    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; call = 1'b0; ret = 1'b0; jump = 1'b0;
        callAddr = '0; jumpAddr = '0;
        step(); step();
        check_eq("rst_pc", pc, 0);
        check_eq("rst_fv", fetchValid, 1);
        check_eq("rst_ws", writeStack, 0);
        check_eq("rst_rs", readStack, 0);
        check_eq("rst_trap", trap, 0);
        check_eq("rst_stackin", stackIn, 0);

        // Free-running increment after reset release.
        reset = 1'b0;
        check_eq("inc_pc0", pc, 0);
        step(); check_eq("inc_pc1", pc, 1);
        step(); check_eq("inc_pc2", pc, 2);
        check_eq("inc_fv", fetchValid, 1);
        check_eq("inc_ws", writeStack, 0);
        check_eq("inc_rs", readStack, 0);

        // Jump to 0x0042, start a return, then reset asynchronously mid-cycle.
        jump = 1'b1; jumpAddr = 13'h0042;
        step(); jump = 1'b0;
        check_eq("jmp42_pc", pc, 13'h0042);
        ret = 1'b1;
        step(); ret = 1'b0;
        check_eq("ret42_rs", readStack, 1);
        check_eq("ret42_fv", fetchValid, 0);
        #2 reset = 1'b1;
        #1;
        check_eq("arst_pc", pc, 0);
        check_eq("arst_rs", readStack, 0);
        check_eq("arst_ws", writeStack, 0);
        check_eq("arst_trap", trap, 0);
        check_eq("arst_fv", fetchValid, 1);
        step(); reset = 1'b0;
        step();
        check_eq("arst_nostale_pc", pc, 1);
        check_eq("arst_nostale_fv", fetchValid, 1);
        check_eq("arst_nostale_rs", readStack, 0);

        // Call from 0x0005 to 0x0100, immediately followed by ret.
        jump = 1'b1; jumpAddr = 13'h0005;
        step(); jump = 1'b0;
        check_eq("jmp5_pc", pc, 13'h0005);
        call = 1'b1; callAddr = 13'h0100;
        step(); call = 1'b0; ret = 1'b1;
        check_eq("call_pc", pc, 13'h0100);
        check_eq("call_ws", writeStack, 1);
        check_eq("call_stackin", stackIn, 13'h0006);
        step(); ret = 1'b0;
        check_eq("ret_ws_off", writeStack, 0);
        check_eq("ret_rs", readStack, 1);
        check_eq("ret_fv0", fetchValid, 0);
        check_eq("ret_pc_hold", pc, 13'h0100);
        step();
        check_eq("retw_rs", readStack, 0);
        check_eq("retw_fv", fetchValid, 0);
        step();
        check_eq("retd_pc", pc, 13'h0006);
        check_eq("retd_fv", fetchValid, 1);
        step();
        check_eq("retd_inc", pc, 13'h0007);

        // Return on an empty stack: fault must redirect to the trap vector.
        ret = 1'b1;
        step(); ret = 1'b0;
        check_eq("eret_rs", readStack, 1);
        step();
        check_eq("eret_wait_fv", fetchValid, 0);
        check_eq("eret_ovf", stackOverflow, 1);
        step();
        check_eq("eret_trapst_pc", pc, 13'h0007);
        check_eq("eret_trapst_fv", fetchValid, 0);
        check_eq("eret_trapst_rs", readStack, 0);
        step();
        check_eq("trap_pc", pc, 13'h0010);
        check_eq("trap_flag", trap, 1);
        check_eq("trap_fv", fetchValid, 1);
        step();
        check_eq("trap_inc", pc, 13'h0011);
        check_eq("trap_sticky", trap, 1);

        // Call beats jump when both are asserted.
        call = 1'b1; callAddr = 13'h0020; jump = 1'b1; jumpAddr = 13'h0030;
        step(); call = 1'b0; jump = 1'b0;
        check_eq("prio_pc", pc, 13'h0020);
        check_eq("prio_ws", writeStack, 1);
        check_eq("prio_stackin", stackIn, 13'h0012);

        // Wrap at the top of the address space.
        jump = 1'b1; jumpAddr = 13'h1FFF;
        step(); jump = 1'b0;
        check_eq("wrap_pc_top", pc, 13'h1FFF);
        step();
        check_eq("wrap_pc_zero", pc, 13'h0000);

        // Stall drops a held call request.
        stall = 1'b1; call = 1'b1; callAddr = 13'h0ABC;
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("stall_pc", pc, 13'h0000);
            check_eq("stall_ws", writeStack, 0);
        end
        stall = 1'b0; call = 1'b0;
        step();
        check_eq("unstall_pc", pc, 13'h0001);
        check_eq("trap_held", trap, 1);

        // Only reset clears trap.
        reset = 1'b1;
        #1;
        check_eq("trap_cleared", trap, 0);
        check_eq("trap_clr_pc", pc, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
